// File: rtl/tetris_cmd_sched_pkg.sv
// Shared types for the tetris command path: the core state/command encoding,
// the key-request bit order used by the input decoder, and key-clear helper.
package tetris_cmd_sched_pkg;

  typedef enum logic [3:0] {
    NONE,
    INIT,
    WAIT,
    END,
    BAR,
    DROP,
    HOLD,
    ROTATE,
    ROTATE_REV,
    LEFT,
    RIGHT,
    DOWN
  } state_type;

  localparam int KEY_W          = 7;
  localparam int KEY_DOWN       = 0;
  localparam int KEY_RIGHT      = 1;
  localparam int KEY_LEFT       = 2;
  localparam int KEY_ROTATE_REV = 3;
  localparam int KEY_ROTATE     = 4;
  localparam int KEY_HOLD       = 5;
  localparam int KEY_DROP       = 6;

  localparam int BAR_W = 10;

  // DROP lands the piece, so any queued soft-drop is stale once it issues.
  function automatic logic [KEY_W-1:0] key_clear_mask(state_type cmd);
    logic [KEY_W-1:0] mask;
    mask = '0;
    case (cmd)
      DROP: begin
        mask[KEY_DROP] = 1'b1;
        mask[KEY_DOWN] = 1'b1;
      end
      HOLD:       mask[KEY_HOLD]       = 1'b1;
      ROTATE:     mask[KEY_ROTATE]     = 1'b1;
      ROTATE_REV: mask[KEY_ROTATE_REV] = 1'b1;
      LEFT:       mask[KEY_LEFT]       = 1'b1;
      RIGHT:      mask[KEY_RIGHT]      = 1'b1;
      DOWN:       mask[KEY_DOWN]       = 1'b1;
      default:    mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/tetris_cmd_sched_bar_fifo.sv
// Garbage-row FIFO: zero-latency head read, simultaneous push/pop, and a
// registered overflow pulse when a push is refused.
module bar_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tetris_cmd_sched.sv
// Command scheduler for the tetris core: latches key/gravity/garbage requests
// and issues at most one prioritised ctrl pulse per WAIT visit of the core.
module tetris_cmd_sched
  import tetris_cmd_sched_pkg::*;
#(
  parameter int unsigned GRAVITY_BASE = 50_000_000,
  parameter int unsigned GRAVITY_STEP = 4_500_000,
  parameter int unsigned BAR_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_req,
  input  logic             start_req,
  input  logic             bar_valid,
  input  logic [BAR_W-1:0] bar_in,
  input  state_type        core_state,
  input  logic [15:0]      score,
  output state_type        ctrl,
  output logic [BAR_W-1:0] bar_mask,
  output logic [3:0]       level,
  output logic             bar_overflow
);

  localparam int CNT_W = $clog2(GRAVITY_BASE + 1);

  logic [KEY_W-1:0] pend;
  logic [KEY_W-1:0] req;
  logic             start_pend;
  logic             grav_pend;
  logic             grav_now;
  logic [CNT_W-1:0] grav_cnt;
  logic [31:0]      period;
  logic             issued;
  logic             running;
  logic             bar_push;
  logic             bar_empty;
  state_type        cmd;

  assign level   = (score[15:8] != 8'd0) ? 4'd9 : score[7:4];
  assign period  = GRAVITY_BASE - 32'(level) * GRAVITY_STEP;
  assign running = (core_state != INIT) && (core_state != END);

  // Compare with >= so a level-up that shortens the period still wraps.
  assign grav_now = running && ((32'(grav_cnt) + 32'd1) >= period);
  assign req      = pend | key_req;
  assign bar_push = bar_valid && (bar_in != '0);

  bar_fifo #(
    .DEPTH (BAR_DEPTH),
    .WIDTH (BAR_W)
  ) u_bar_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bar_push),
    .din      (bar_in),
    .pop      (core_state == BAR),
    .dout     (bar_mask),
    .empty    (bar_empty),
    .overflow (bar_overflow)
  );

  always_comb begin
    cmd = NONE;
    if (!issued) begin
      if (!running) begin
        if (start_req || start_pend) cmd = DOWN;
      end else if (core_state == WAIT) begin
        if (!bar_empty)                                   cmd = BAR;
        else if (req[KEY_DROP])                           cmd = DROP;
        else if (req[KEY_HOLD])                           cmd = HOLD;
        else if (req[KEY_ROTATE])                         cmd = ROTATE;
        else if (req[KEY_ROTATE_REV])                     cmd = ROTATE_REV;
        else if (req[KEY_LEFT])                           cmd = LEFT;
        else if (req[KEY_RIGHT])                          cmd = RIGHT;
        else if (req[KEY_DOWN] || grav_pend || grav_now)  cmd = DOWN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl       <= NONE;
      pend       <= '0;
      start_pend <= 1'b0;
      grav_pend  <= 1'b0;
      grav_cnt   <= '0;
      issued     <= 1'b0;
    end else begin
      ctrl <= cmd;

      if (cmd != NONE)              issued <= 1'b1;
      else if (core_state != WAIT)  issued <= 1'b0;

      if (!running) begin
        pend       <= '0;
        grav_pend  <= 1'b0;
        grav_cnt   <= '0;
        start_pend <= (start_pend || start_req) && (cmd == NONE);
      end else begin
        start_pend <= 1'b0;
        pend       <= req & ~key_clear_mask(cmd);
        // A hard or soft drop satisfies gravity, so the period restarts.
        if (cmd == DOWN || cmd == DROP) begin
          grav_pend <= 1'b0;
          grav_cnt  <= '0;
        end else begin
          grav_pend <= grav_pend || grav_now;
          grav_cnt  <= grav_now ? '0 : grav_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
